// File: rtl/memory_array_pkg.sv
// Shared constants for memory_array.
//   MEM_TYPE_REG  : register array, combinational read, array cleared by reset
//   MEM_TYPE_SYNC : synchronous-read array, only the output register is reset
//   mem_depth()   : number of words addressed by an address of the given width
package memory_array_pkg;

   localparam string MEM_TYPE_REG  = "REG";
   localparam string MEM_TYPE_SYNC = "SYNC";

   function automatic int unsigned mem_depth(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

endpackage

// File: rtl/memory_array_if.sv
// Access bus for memory_array.
//   we   : write enable, sampled on rising clk
//   addr : shared read/write word address
//   din  : write data
//   dout : read data
// master = the block issuing accesses, slave = the memory.
interface memory_array_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);

   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] din;
   logic [DATA_WIDTH-1:0] dout;

   modport master (
      output we,
      output addr,
      output din,
      input  dout
   );

   modport slave (
      input  we,
      input  addr,
      input  din,
      output dout
   );

endinterface

// File: rtl/memory_array.sv
// Single-port word memory with selectable storage style.
//   MEM_TYPE "REG"  : dout = mem[addr] combinationally; reset clears every word.
//   MEM_TYPE "SYNC" : dout registered from mem[addr] each edge (read-first);
//                     reset clears only the dout register.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : memory_array_if slave (we, addr, din -> dout)
module memory_array
   import memory_array_pkg::*;
#(
   parameter string MEM_TYPE   = MEM_TYPE_REG,
   parameter int    DATA_WIDTH = 8,
   parameter int    ADDR_WIDTH = 4
) (
   input logic           clk,
   input logic           rst_n,
   memory_array_if.slave bus
);

   localparam int DEPTH = int'(mem_depth(ADDR_WIDTH));

   typedef logic [DATA_WIDTH-1:0] word_t;

   word_t mem_q [DEPTH];
   word_t mem_d [DEPTH];

   // Gating with rst_n discards a write that lands on an edge while reset is
   // held; the SYNC array has no reset of its own to do this.
   always_comb begin
      mem_d = mem_q;
      if (bus.we && rst_n) begin
         mem_d[bus.addr] = bus.din;
      end
   end

   if (DATA_WIDTH < 1) begin : g_bad_width
      $fatal(1, "memory_array: DATA_WIDTH must be at least 1");
   end

   if (MEM_TYPE == MEM_TYPE_REG) begin : g_reg

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
               mem_q[i] <= '0;
            end
         end else begin
            mem_q <= mem_d;
         end
      end

      assign bus.dout = mem_q[bus.addr];

   end else if (MEM_TYPE == MEM_TYPE_SYNC) begin : g_sync

      word_t dout_q;
      word_t dout_d;

      // Array contents survive reset.
      always_ff @(posedge clk) begin
         mem_q <= mem_d;
      end

      // Reads the pre-write contents, so a same-address write is read-first.
      always_comb begin
         dout_d = mem_q[bus.addr];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dout_q <= '0;
         end else begin
            dout_q <= dout_d;
         end
      end

      assign bus.dout = dout_q;

   end else begin : g_bad_type
      $fatal(1, "memory_array: MEM_TYPE must be REG or SYNC");
   end

endmodule

// File: tb/tb_memory_array.sv
module tb_memory_array;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic clk;
   logic rst_n;

   int checks = 0;
   int errors = 0;

   // Reference model: plain arrays updated from the behavioural rules.
   logic [DW-1:0] model_reg  [DEPTH];
   logic [DW-1:0] model_sync [DEPTH];
   logic [DW-1:0] model_sync_dout;

   memory_array_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_reg  ();
   memory_array_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_sync ();

   memory_array #(.MEM_TYPE("REG"), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_reg.slave)
   );

   memory_array #(.MEM_TYPE("SYNC"), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_sync.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if_reg.we   = w;
      if_reg.addr = a;
      if_reg.din  = d;
      if_sync.we   = w;
      if_sync.addr = a;
      if_sync.din  = d;
   endtask

   // Apply what a rising edge does, using the inputs present at that edge.
   task automatic model_edge(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (rst_n) begin
         model_sync_dout = model_sync[a];
         if (w) begin
            model_reg[a]  = d;
            model_sync[a] = d;
         end
      end
   endtask

   // One clock: drive at negedge, model at posedge, return 1 time unit later.
   task automatic step(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      drive(w, a, d);
      @(posedge clk);
      model_edge(w, a, d);
      #1;
   endtask

   // Change the address between edges without a write.
   task automatic set_addr(input logic [AW-1:0] a);
      drive(1'b0, a, '0);
      #1;
   endtask

   task automatic assert_reset();
      rst_n = 1'b0;
      for (int i = 0; i < DEPTH; i++) model_reg[i] = '0;
      model_sync_dout = '0;
      #1;
   endtask

   task automatic test_reset();
      drive(1'b0, '0, '0);
      rst_n = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         model_reg[i]  = '0;
         model_sync[i] = '0;
      end
      model_sync_dout = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (if_sync.dout !== 8'h00) begin
         errors++;
         $display("FAIL reset_sync_dout: got %h expected 00", if_sync.dout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < DEPTH; i++) begin
         set_addr(AW'(i));
         checks++;
         if (if_reg.dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_reg_word%0d: got %h expected 00", i, if_reg.dout);
         end
      end
      // Give the SYNC array known contents.
      for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), 8'h00);
      step(1'b0, 4'h0, 8'h00);
      checks++;
      if (if_sync.dout !== 8'h00) begin
         errors++;
         $display("FAIL reset_sync_prefill: got %h expected 00", if_sync.dout);
      end
   endtask

   task automatic test_basic();
      step(1'b1, 4'h1, 8'hAA);
      step(1'b1, 4'h2, 8'h55);
      set_addr(4'h1);
      checks++;
      if (if_reg.dout !== 8'hAA) begin
         errors++;
         $display("FAIL basic_reg_addr1: got %h expected aa", if_reg.dout);
      end
      set_addr(4'h2);
      checks++;
      if (if_reg.dout !== 8'h55) begin
         errors++;
         $display("FAIL basic_reg_addr2: got %h expected 55", if_reg.dout);
      end
      step(1'b0, 4'h1, 8'h00);
      checks++;
      if (if_sync.dout !== 8'hAA) begin
         errors++;
         $display("FAIL basic_sync_addr1: got %h expected aa", if_sync.dout);
      end
      step(1'b0, 4'h2, 8'h00);
      checks++;
      if (if_sync.dout !== 8'h55) begin
         errors++;
         $display("FAIL basic_sync_addr2: got %h expected 55", if_sync.dout);
      end
   endtask

   task automatic test_boundary();
      step(1'b1, 4'hF, 8'hFF);
      step(1'b1, 4'h0, 8'h00);
      for (int i = 0; i < DEPTH; i++) begin
         set_addr(AW'(i));
         checks++;
         if (if_reg.dout !== model_reg[i]) begin
            errors++;
            $display("FAIL boundary_reg_word%0d: got %h expected %h", i, if_reg.dout, model_reg[i]);
         end
      end
      step(1'b0, 4'hF, 8'h00);
      checks++;
      if (if_sync.dout !== 8'hFF) begin
         errors++;
         $display("FAIL boundary_sync_addrF: got %h expected ff", if_sync.dout);
      end
   endtask

   task automatic test_back_to_back();
      step(1'b1, 4'h3, 8'h33);
      step(1'b1, 4'h3, 8'h44);
      checks++;
      if (if_reg.dout !== 8'h44) begin
         errors++;
         $display("FAIL b2b_reg_addr3: got %h expected 44", if_reg.dout);
      end
      // Read-first: the second edge returned the first write.
      checks++;
      if (if_sync.dout !== 8'h33) begin
         errors++;
         $display("FAIL b2b_sync_readfirst: got %h expected 33", if_sync.dout);
      end
      step(1'b0, 4'h3, 8'h00);
      checks++;
      if (if_sync.dout !== 8'h44) begin
         errors++;
         $display("FAIL b2b_sync_addr3: got %h expected 44", if_sync.dout);
      end
   endtask

   task automatic test_truncation();
      logic [AW:0] wide_addr;
      step(1'b1, 4'h0, 8'h5A);
      wide_addr = 5'h10;
      set_addr(wide_addr[AW-1:0]);
      checks++;
      if (if_reg.dout !== 8'h5A) begin
         errors++;
         $display("FAIL trunc_reg_addr10: got %h expected 5a", if_reg.dout);
      end
   endtask

   task automatic test_read_during_write();
      step(1'b1, 4'h7, 8'hAA);
      checks++;
      if (if_sync.dout !== 8'h00) begin
         errors++;
         $display("FAIL rdw_sync_old: got %h expected 00", if_sync.dout);
      end
      checks++;
      if (if_reg.dout !== 8'hAA) begin
         errors++;
         $display("FAIL rdw_reg_immediate: got %h expected aa", if_reg.dout);
      end
      step(1'b0, 4'h7, 8'h00);
      checks++;
      if (if_sync.dout !== 8'hAA) begin
         errors++;
         $display("FAIL rdw_sync_new: got %h expected aa", if_sync.dout);
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 4'h1, 8'hAA);
      step(1'b0, 4'h1, 8'h00);
      // Between edges: reset must act without a clock.
      assert_reset();
      checks++;
      if (if_reg.dout !== 8'h00) begin
         errors++;
         $display("FAIL midrst_reg_dout: got %h expected 00", if_reg.dout);
      end
      checks++;
      if (if_sync.dout !== 8'h00) begin
         errors++;
         $display("FAIL midrst_sync_dout: got %h expected 00", if_sync.dout);
      end
      // Write while reset held across an edge must be discarded.
      @(negedge clk);
      drive(1'b1, 4'h5, 8'h77);
      @(posedge clk);
      model_edge(1'b1, 4'h5, 8'h77);
      #1;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 4'h1, 8'h00);
      #1;
      checks++;
      if (if_reg.dout !== 8'h00) begin
         errors++;
         $display("FAIL midrst_reg_addr1: got %h expected 00", if_reg.dout);
      end
      set_addr(4'h5);
      checks++;
      if (if_reg.dout !== 8'h00) begin
         errors++;
         $display("FAIL midrst_reg_discard: got %h expected 00", if_reg.dout);
      end
      step(1'b0, 4'h1, 8'h00);
      checks++;
      if (if_sync.dout !== 8'hAA) begin
         errors++;
         $display("FAIL midrst_sync_addr1: got %h expected aa", if_sync.dout);
      end
      step(1'b0, 4'h5, 8'h00);
      checks++;
      if (if_sync.dout !== model_sync[5]) begin
         errors++;
         $display("FAIL midrst_sync_discard: got %h expected %h", if_sync.dout, model_sync[5]);
      end
      // First write after release lands on the first enabled edge.
      step(1'b1, 4'h9, 8'hC3);
      checks++;
      if (if_reg.dout !== 8'hC3) begin
         errors++;
         $display("FAIL midrst_first_write: got %h expected c3", if_reg.dout);
      end
   endtask

   task automatic test_random();
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      for (int n = 0; n < 300; n++) begin
         w = 1'($urandom_range(0, 1));
         a = AW'($urandom_range(0, DEPTH - 1));
         d = DW'($urandom);
         @(negedge clk);
         drive(w, a, d);
         #1;
         checks++;
         if (if_reg.dout !== model_reg[a]) begin
            errors++;
            $display("FAIL rand_reg_comb[%0d]: addr %h got %h expected %h", n, a, if_reg.dout, model_reg[a]);
         end
         @(posedge clk);
         model_edge(w, a, d);
         #1;
         checks++;
         if (if_reg.dout !== model_reg[a]) begin
            errors++;
            $display("FAIL rand_reg_post[%0d]: addr %h got %h expected %h", n, a, if_reg.dout, model_reg[a]);
         end
         checks++;
         if (if_sync.dout !== model_sync_dout) begin
            errors++;
            $display("FAIL rand_sync[%0d]: addr %h got %h expected %h", n, a, if_sync.dout, model_sync_dout);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_back_to_back();
      test_truncation();
      test_read_during_write();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_array.md
MEMORY_ARRAY -- requirements
Module: memory_array

Interface
REQ-001 Parameter MEM_TYPE, default "REG": storage style; legal values "REG" (register array, combinational read) and "SYNC" (synchronous-read array).
REQ-002 Parameter DATA_WIDTH, default 8: word width in bits, minimum 1.
REQ-003 Parameter ADDR_WIDTH, default 4: address width; depth SHALL be 2**ADDR_WIDTH words.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 we  input  1  write enable, sampled on rising clk.
REQ-007 addr  input  ADDR_WIDTH  shared read/write word address.
REQ-008 din  input  DATA_WIDTH  write data.
REQ-009 dout  output  DATA_WIDTH  read data.

Function
REQ-010 Write: on rising clk with rst_n=1 and we=1, the array SHALL store din at mem[addr]; no other word SHALL change.
REQ-011 we=0 SHALL leave the array unchanged; the block has no separate read enable, so reads are continuous.
REQ-012 MEM_TYPE "REG": dout SHALL equal mem[addr] combinationally, with zero-cycle latency from an addr change.
REQ-013 MEM_TYPE "REG": a word written at edge N SHALL appear on dout immediately after edge N while addr still selects it.
REQ-014 MEM_TYPE "SYNC": dout SHALL be a register loaded with mem[addr] on every rising clk, giving one-cycle read latency.
REQ-015 MEM_TYPE "SYNC": on read-during-write to the same address, dout SHALL return the old contents (read-first); the new data SHALL appear on the next edge.
REQ-016 Back-to-back writes to the same address SHALL resolve last-write-wins (e.g. 0x33 then 0x44 leaves 0x44).
REQ-017 Address range: every value 0..2**ADDR_WIDTH-1 SHALL be valid, including 0 and all-ones.
REQ-018 Address range: there is no out-of-range case; wider values driven by the parent are truncated to ADDR_WIDTH bits before entry (e.g. 0x10 with ADDR_WIDTH=4 addresses word 0).
REQ-019 Any MEM_TYPE other than "REG" or "SYNC" SHALL cause an elaboration-time error.
REQ-020 Outputs SHALL never be X after reset when driven inputs are known.

Reset
REQ-021 rst_n=0 SHALL act immediately, independent of clk.
REQ-022 MEM_TYPE "REG": reset SHALL clear every array word to 0, so dout reads 0 for every address.
REQ-023 MEM_TYPE "SYNC": reset SHALL clear the dout register to 0; array contents SHALL be left unchanged.
REQ-024 A write coincident with asserted reset SHALL be discarded; reset dominates.
REQ-025 After rst_n deasserts, the first write SHALL occur on the first rising clk where we=1.

Structure
REQ-026 Package memory_array_pkg SHALL hold the MEM_TYPE legal-value string constants and a depth function (2**ADDR_WIDTH).
REQ-027 No sub-modules: both storage styles SHALL be selected by a generate block inside memory_array.

Verification
REQ-028 REG, DATA_WIDTH=8, ADDR_WIDTH=4: write 0xAA@1 then 0x55@2; read addr 1 -> 0xAA, read addr 2 -> 0x55.
REQ-029 REG: write 0xFF@0xF then 0x00@0x0; read 0xF -> 0xFF and 0x0 -> 0x00, with other locations unchanged.
REQ-030 REG: write 0x33@3 then 0x44@3 on consecutive edges; read addr 3 -> 0x44.
REQ-031 REG: write 0x5A@0, drive addr 0x10 truncated to 4'h0 -> dout 0x5A.
REQ-032 SYNC: write 0xAA@1 while reading addr 1 on the same edge -> dout shows old value (0x00 after reset), then 0xAA one edge later.
REQ-033 Reset mid-operation: write 0xAA@1, pulse rst_n low between clock edges.
REQ-034 Reset mid-operation, REG: dout drops to 0 immediately and a later read of addr 1 -> 0x00.
REQ-035 Reset mid-operation, SYNC: dout drops to 0 immediately and a later read of addr 1 -> 0xAA.
